rs_wakeup_select: RTL

Parametrised age-ordered reservation station with internal operand-readiness tracking, tag-broadcast wakeup and a valid/ready issue handshake. It sits between rename/dispatch and one execution unit (ALU, LSU or BRU instance). It supersedes the fixed two-wide, PRF-polling station. It accepts up to DISPATCH_WIDTH instructions per cycle and issues the oldest ready entry each cycle.

---
 rtl/rs_wakeup_select_if.sv | 37 +++
 rtl/rs_wakeup_select.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rs_wakeup_select_if.sv
// Dispatch, wakeup and issue bundle of the wakeup/select reservation station.
// The station takes the slave side; the rename/dispatch and execution stages take the master side.
interface rs_wakeup_select_if #(
  parameter int unsigned NUM_ENTRIES    = 16,
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned NUM_WAKEUP     = 2,
  parameter int unsigned TAG_W          = 6,
  parameter int unsigned PAYLOAD_W      = 96
);
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES) + 1;

  logic [DISPATCH_WIDTH-1:0]           disp_valid;
  logic [DISPATCH_WIDTH*TAG_W-1:0]     disp_src1_tag;
  logic [DISPATCH_WIDTH*TAG_W-1:0]     disp_src2_tag;
  logic [DISPATCH_WIDTH-1:0]           disp_src1_rdy;
  logic [DISPATCH_WIDTH-1:0]           disp_src2_rdy;
  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] disp_payload;
  logic                                disp_ready;
  logic [NUM_WAKEUP-1:0]               wake_valid;
  logic [NUM_WAKEUP*TAG_W-1:0]         wake_tag;
  logic                                issue_valid;
  logic                                issue_ready;
  logic [PAYLOAD_W-1:0]                issue_payload;
  logic [CNT_W-1:0]                    num_free;

  modport master (
    output disp_valid, disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           disp_payload, wake_valid, wake_tag, issue_ready,
    input  disp_ready, issue_valid, issue_payload, num_free
  );

  modport slave (
    input  disp_valid, disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           disp_payload, wake_valid, wake_tag, issue_ready,
    output disp_ready, issue_valid, issue_payload, num_free
  );
endinterface

// File: rtl/rs_wakeup_select.sv
// Age-ordered reservation station: tracks operand readiness through tag wakeup
// and issues the oldest ready entry through a valid/ready handshake.
module rs_wakeup_select #(
  parameter int unsigned NUM_ENTRIES    = 16,
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned NUM_WAKEUP     = 2,
  parameter int unsigned TAG_W          = 6,
  parameter int unsigned PAYLOAD_W      = 96
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  rs_wakeup_select_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES) + 1;

  typedef logic [NUM_ENTRIES-1:0] mask_t;

  mask_t                valid_q;
  mask_t                src1_rdy_q;
  mask_t                src2_rdy_q;
  logic [TAG_W-1:0]     src1_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]     src2_tag_q [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0] payload_q  [NUM_ENTRIES];
  mask_t                older_q    [NUM_ENTRIES];
  logic [CNT_W-1:0]     num_free_q;

  mask_t                ready;
  mask_t                grant;
  logic                 disp_ready;
  logic                 issue_fire;
  logic [PAYLOAD_W-1:0] issue_payload;
  mask_t                alloc_oh   [DISPATCH_WIDTH];
  mask_t                alloc_any;
  logic [CNT_W-1:0]     n_alloc;
  mask_t                valid_nxt;
  mask_t                src1_rdy_nxt;
  mask_t                src2_rdy_nxt;
  mask_t                older_nxt  [NUM_ENTRIES];
  logic [CNT_W-1:0]     num_free_nxt;

  function automatic logic wake_hit(input logic [TAG_W-1:0]            tag,
                                    input logic [NUM_WAKEUP-1:0]       wv,
                                    input logic [NUM_WAKEUP*TAG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int unsigned w = 0; w < NUM_WAKEUP; w++) begin
      if (wv[w] && (wt[w*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign ready      = valid_q & src1_rdy_q & src2_rdy_q;
  assign disp_ready = (num_free_q >= CNT_W'(DISPATCH_WIDTH));
  assign issue_fire = (|ready) & bus.issue_ready;

  // An entry wins when no ready entry is marked older in its age row.
  always_comb begin
    grant         = '0;
    issue_payload = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      grant[i] = ready[i] & ~|(older_q[i] & ready);
      if (grant[i]) issue_payload = issue_payload | payload_q[i];
    end
  end

  // Lowest free slot to lowest valid lane; slots freed this cycle still read valid.
  always_comb begin
    logic found;
    alloc_any = '0;
    n_alloc   = '0;
    for (int unsigned l = 0; l < DISPATCH_WIDTH; l++) begin
      alloc_oh[l] = '0;
      found       = 1'b0;
      if (bus.disp_valid[l] && disp_ready) begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
          if (!found && !valid_q[i] && !alloc_any[i]) begin
            alloc_oh[l][i] = 1'b1;
            alloc_any[i]   = 1'b1;
            found          = 1'b1;
          end
        end
      end
      if (found) n_alloc = n_alloc + 1'b1;
    end
  end

  always_comb begin
    mask_t lower;
    valid_nxt    = valid_q & ~(issue_fire ? grant : '0);
    src1_rdy_nxt = src1_rdy_q;
    src2_rdy_nxt = src2_rdy_q;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      older_nxt[i] = older_q[i];
      if (valid_q[i]) begin
        if (wake_hit(src1_tag_q[i], bus.wake_valid, bus.wake_tag)) src1_rdy_nxt[i] = 1'b1;
        if (wake_hit(src2_tag_q[i], bus.wake_valid, bus.wake_tag)) src2_rdy_nxt[i] = 1'b1;
      end
    end
    // New rows see every resident entry and every lower lane of the group as older.
    lower = '0;
    for (int unsigned l = 0; l < DISPATCH_WIDTH; l++) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (alloc_oh[l][i]) begin
          valid_nxt[i]    = 1'b1;
          src1_rdy_nxt[i] = bus.disp_src1_rdy[l] |
                            wake_hit(bus.disp_src1_tag[l*TAG_W +: TAG_W], bus.wake_valid, bus.wake_tag);
          src2_rdy_nxt[i] = bus.disp_src2_rdy[l] |
                            wake_hit(bus.disp_src2_tag[l*TAG_W +: TAG_W], bus.wake_valid, bus.wake_tag);
          older_nxt[i]    = valid_q | lower;
        end
      end
      lower = lower | alloc_oh[l];
    end
    if (issue_fire) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) older_nxt[i] = older_nxt[i] & ~grant;
    end
  end

  assign num_free_nxt = num_free_q - n_alloc + CNT_W'(issue_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      num_free_q <= CNT_W'(NUM_ENTRIES);
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) older_q[i] <= '0;
    end else if (flush) begin
      valid_q    <= '0;
      num_free_q <= CNT_W'(NUM_ENTRIES);
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) older_q[i] <= '0;
    end else begin
      valid_q    <= valid_nxt;
      src1_rdy_q <= src1_rdy_nxt;
      src2_rdy_q <= src2_rdy_nxt;
      num_free_q <= num_free_nxt;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        older_q[i] <= older_nxt[i];
        for (int unsigned l = 0; l < DISPATCH_WIDTH; l++) begin
          if (alloc_oh[l][i]) begin
            src1_tag_q[i] <= bus.disp_src1_tag[l*TAG_W +: TAG_W];
            src2_tag_q[i] <= bus.disp_src2_tag[l*TAG_W +: TAG_W];
            payload_q[i]  <= bus.disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
          end
        end
      end
    end
  end

  assign bus.disp_ready    = disp_ready;
  assign bus.issue_valid   = |ready;
  assign bus.issue_payload = issue_payload;
  assign bus.num_free      = num_free_q;
endmodule
